muldiv_unit: RTL

Iterative multiply/divide unit implementing the RV32M (generalised to WIDTH bits) operations selected by func3. It sits beside the ALU in the execute stage: the ALU control issues ALU_MUL-class operations here instead of to the single-cycle ALU. It accepts one operation via a start/busy/done handshake, computes in a fixed number of cycles, and holds the result until the next operation. The pipeline stalls while busy is high.

---
 rtl/muldiv_pkg.sv | 30 +++
 rtl/muldiv_unit_cond_negate.sv | 19 +
 rtl/muldiv_unit.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative multiply/divide unit and the ALU control that issues to it.
package muldiv_pkg;

   localparam logic [2:0] MUL    = 3'b000;
   localparam logic [2:0] MULH   = 3'b001;
   localparam logic [2:0] MULHSU = 3'b010;
   localparam logic [2:0] MULHU  = 3'b011;
   localparam logic [2:0] DIV    = 3'b100;
   localparam logic [2:0] DIVU   = 3'b101;
   localparam logic [2:0] REM    = 3'b110;
   localparam logic [2:0] REMU   = 3'b111;

   // ALU control class that the decoder routes to this unit instead of the single-cycle ALU.
   localparam logic [3:0] ALU_MUL = 4'b1010;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      CALC   = 2'd1,
      FINISH = 2'd2
   } state_e;

   function automatic logic op_a_is_signed(input logic [2:0] f);
      return (f == MULH) || (f == MULHSU) || (f == DIV) || (f == REM);
   endfunction

   function automatic logic op_b_is_signed(input logic [2:0] f);
      return (f == MULH) || (f == DIV) || (f == REM);
   endfunction

endpackage

// File: rtl/muldiv_unit_cond_negate.sv
// Combinational two's-complement conditional negation: dout = neg ? -din : din.
module cond_negate #(
   parameter int WIDTH = 32
) (
   input  logic             neg,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout
);

   // Negate by invert-plus-one when requested, otherwise pass through.
   always_comb begin
      if (neg) begin
         dout = ~din + WIDTH'(1);
      end else begin
         dout = din;
      end
   end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M-style multiply/divide unit: shift-add multiply, restoring divide,
// fixed WIDTH+1 cycle latency with a start/busy/done handshake.
module muldiv_unit
   import muldiv_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             arst,
   input  logic             start,
   input  logic [2:0]       func3,
   input  logic [WIDTH-1:0] op_a,
   input  logic [WIDTH-1:0] op_b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result
);

   localparam int DW    = 2 * WIDTH;
   localparam int CNT_W = $clog2(WIDTH) + 1;
   localparam logic [CNT_W-1:0] LAST     = CNT_W'(WIDTH - 1);
   localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};
   localparam logic [WIDTH-1:0] MIN_NEG  = {1'b1, {(WIDTH-1){1'b0}}};

   state_e             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [2:0]         func3_q, func3_d;
   logic [WIDTH-1:0]   opa_q, opa_d;
   logic [WIDTH-1:0]   a_q, a_d;
   logic [WIDTH-1:0]   b_q, b_d;
   logic               neg_a_q, neg_a_d;
   logic               neg_b_q, neg_b_d;
   logic               div_zero_q, div_zero_d;
   logic               ovf_q, ovf_d;
   logic [DW-1:0]      prod_q, prod_d;
   logic [WIDTH:0]     rem_q, rem_d;
   logic [WIDTH-1:0]   quo_q, quo_d;
   logic               busy_q, busy_d;
   logic               done_q, done_d;
   logic [WIDTH-1:0]   result_q, result_d;

   logic               a_sgn, b_sgn;
   logic [WIDTH-1:0]   mag_a, mag_b;
   logic [DW-1:0]      prod_fix;
   logic [WIDTH-1:0]   quo_fix, rem_fix, fix_res;
   logic [WIDTH:0]     mul_sum;
   logic [WIDTH+1:0]   div_shift, div_diff;

   assign a_sgn = op_a_is_signed(func3) & op_a[WIDTH-1];
   assign b_sgn = op_b_is_signed(func3) & op_b[WIDTH-1];

   cond_negate #(.WIDTH(WIDTH)) u_mag_a (.neg(a_sgn), .din(op_a), .dout(mag_a));
   cond_negate #(.WIDTH(WIDTH)) u_mag_b (.neg(b_sgn), .din(op_b), .dout(mag_b));

   cond_negate #(.WIDTH(DW))    u_fix_prod (.neg(neg_a_q ^ neg_b_q), .din(prod_q),             .dout(prod_fix));
   cond_negate #(.WIDTH(WIDTH)) u_fix_quo  (.neg(neg_a_q ^ neg_b_q), .din(quo_q),              .dout(quo_fix));
   cond_negate #(.WIDTH(WIDTH)) u_fix_rem  (.neg(neg_a_q),           .din(rem_q[WIDTH-1:0]),   .dout(rem_fix));

   // Final result selection, with divide-by-zero and signed-overflow overrides.
   always_comb begin
      fix_res = '0;
      case (func3_q)
         MUL:                 fix_res = prod_fix[WIDTH-1:0];
         MULH, MULHSU, MULHU: fix_res = prod_fix[DW-1:WIDTH];
         DIV, DIVU: begin
            if (div_zero_q) begin
               fix_res = ALL_ONES;
            end else if (ovf_q) begin
               fix_res = opa_q;
            end else begin
               fix_res = quo_fix;
            end
         end
         REM, REMU: begin
            if (div_zero_q) begin
               fix_res = opa_q;
            end else if (ovf_q) begin
               fix_res = '0;
            end else begin
               fix_res = rem_fix;
            end
         end
         default: fix_res = '0;
      endcase
   end

   // Next-state and datapath iteration for the IDLE/CALC/FINISH sequence.
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      func3_d    = func3_q;
      opa_d      = opa_q;
      a_d        = a_q;
      b_d        = b_q;
      neg_a_d    = neg_a_q;
      neg_b_d    = neg_b_q;
      div_zero_d = div_zero_q;
      ovf_d      = ovf_q;
      prod_d     = prod_q;
      rem_d      = rem_q;
      quo_d      = quo_q;
      busy_d     = busy_q;
      done_d     = 1'b0;
      result_d   = result_q;

      mul_sum   = {1'b0, prod_q[DW-1:WIDTH]} + ({1'b0, a_q} & {(WIDTH+1){prod_q[0]}});
      div_shift = {rem_q, quo_q[WIDTH-1]};
      div_diff  = div_shift - {2'b00, b_q};

      case (state_q)
         IDLE: begin
            if (start) begin
               func3_d    = func3;
               opa_d      = op_a;
               a_d        = mag_a;
               b_d        = mag_b;
               neg_a_d    = a_sgn;
               neg_b_d    = b_sgn;
               div_zero_d = func3[2] & (op_b == '0);
               ovf_d      = ((func3 == DIV) || (func3 == REM)) && (op_a == MIN_NEG) && (op_b == ALL_ONES);
               prod_d     = {{WIDTH{1'b0}}, mag_b};
               rem_d      = '0;
               quo_d      = mag_a;
               cnt_d      = '0;
               busy_d     = 1'b1;
               state_d    = CALC;
            end else begin
               busy_d  = 1'b0;
               state_d = IDLE;
            end
         end
         CALC: begin
            prod_d = {mul_sum, prod_q[WIDTH-1:1]};
            // A borrow out of the trial subtraction means the divisor did not fit: restore.
            if (div_diff[WIDTH+1]) begin
               rem_d = div_shift[WIDTH:0];
               quo_d = {quo_q[WIDTH-2:0], 1'b0};
            end else begin
               rem_d = div_diff[WIDTH:0];
               quo_d = {quo_q[WIDTH-2:0], 1'b1};
            end
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == LAST) begin
               state_d = FINISH;
            end else begin
               state_d = CALC;
            end
         end
         FINISH: begin
            result_d = fix_res;
            done_d   = 1'b1;
            busy_d   = 1'b0;
            state_d  = IDLE;
         end
         default: begin
            busy_d  = 1'b0;
            state_d = IDLE;
         end
      endcase
   end

   // State, datapath and output registers; asynchronous reset aborts any operation.
   always_ff @(posedge clk or posedge arst) begin
      if (arst) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         func3_q    <= 3'b000;
         opa_q      <= '0;
         a_q        <= '0;
         b_q        <= '0;
         neg_a_q    <= 1'b0;
         neg_b_q    <= 1'b0;
         div_zero_q <= 1'b0;
         ovf_q      <= 1'b0;
         prod_q     <= '0;
         rem_q      <= '0;
         quo_q      <= '0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         result_q   <= '0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         func3_q    <= func3_d;
         opa_q      <= opa_d;
         a_q        <= a_d;
         b_q        <= b_d;
         neg_a_q    <= neg_a_d;
         neg_b_q    <= neg_b_d;
         div_zero_q <= div_zero_d;
         ovf_q      <= ovf_d;
         prod_q     <= prod_d;
         rem_q      <= rem_d;
         quo_q      <= quo_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         result_q   <= result_d;
      end
   end

   assign busy   = busy_q;
   assign done   = done_q;
   assign result = result_q;

endmodule
